// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider / enable generator
// Each channel counts to its own divisor and emits either a toggling clock or a one-cycle strobe.
module clk_div_multi #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 26,
  parameter int DEF_DIV = 2000,
  parameter int CH_W    = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              WrEn,
  input  logic [CH_W-1:0]   WrCh,
  input  logic [CNT_W-1:0]  WrDiv,
  input  logic              WrMode,
  input  logic [NUM_CH-1:0] Enable,
  input  logic              SyncAll,
  output logic [NUM_CH-1:0] ClkOut,
  output logic [NUM_CH-1:0] Tick
);

  localparam logic [CNT_W-1:0] DEF_DIV_L = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CH_W:0]    NUM_CH_L  = (CH_W+1)'(NUM_CH);

  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] clk_out_q, clk_out_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] wr_sel;
  logic              wr_hit;

  // Writes to a channel index beyond NUM_CH are dropped entirely.
  assign wr_hit = WrEn && ({1'b0, WrCh} < NUM_CH_L);

  always_comb begin
    div_d     = div_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    clk_out_d = clk_out_q;
    tick_d    = tick_q;
    wr_sel    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = wr_hit && (WrCh == CH_W'(i));
      if (wr_sel[i]) begin
        div_d[i]  = WrDiv;
        mode_d[i] = WrMode;
      end
      // A divisor change always restarts the phase, so cnt never exceeds div.
      if (SyncAll || wr_sel[i]) begin
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b0;
        tick_d[i]    = 1'b0;
      end else if (Enable[i]) begin
        if (cnt_q[i] == div_q[i]) begin
          cnt_d[i]     = '0;
          tick_d[i]    = 1'b1;
          clk_out_d[i] = mode_q[i] ? 1'b1 : ~clk_out_q[i];
        end else begin
          cnt_d[i]  = cnt_q[i] + CNT_ONE;
          tick_d[i] = 1'b0;
          if (mode_q[i]) clk_out_d[i] = 1'b0;
        end
      end else begin
        tick_d[i] = 1'b0;
        if (mode_q[i]) clk_out_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= DEF_DIV_L;
        cnt_q[i] <= '0;
      end
      mode_q    <= '0;
      clk_out_q <= '0;
      tick_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      mode_q    <= mode_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign ClkOut = clk_out_q;
  assign Tick   = tick_q;

endmodule
